// File: rtl/core_pkg.sv
// Shared sizing for the FIR core: tap count, sample/coefficient/output widths.
package core_pkg;
    localparam int CORE_TAPS   = 64;
    localparam int CORE_DATA_W = 16;
    localparam int CORE_COEF_W = 16;
    localparam int CORE_OUT_W  = 41;
    localparam int CORE_ADDR_W = 6;
endpackage

// File: rtl/core_cmem.sv
// Coefficient memory: one synchronous write port, every entry visible in parallel for the MAC.
module core_cmem
    import core_pkg::*;
#(
    parameter int TAPS   = CORE_TAPS,
    parameter int COEF_W = CORE_COEF_W
) (
    input  logic                          clk1,
    input  logic                          rst_i,
    input  logic                          we_i,
    input  logic [CORE_ADDR_W-1:0]        waddr_i,
    input  logic [COEF_W-1:0]             wdata_i,
    output logic [TAPS-1:0][COEF_W-1:0]   coefs_o
);

    logic [TAPS-1:0][COEF_W-1:0] mem_q;

    always_ff @(posedge clk1) begin
        if (rst_i) begin
            mem_q <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign coefs_o = mem_q;

endmodule

// File: rtl/core.sv
// Direct-form FIR: shift delay line on accept, full-width parallel MAC registered into dout.
module core
    import core_pkg::*;
#(
    parameter int TAPS   = CORE_TAPS,
    parameter int DATA_W = CORE_DATA_W,
    parameter int COEF_W = CORE_COEF_W,
    parameter int OUT_W  = CORE_OUT_W
) (
    input  logic                          clk1,
    input  logic                          rstn,
    input  logic                          start,
    input  logic [DATA_W-1:0]             din,
    input  logic                          valid_in,
    input  logic [COEF_W-1:0]             cin,
    input  logic [CORE_ADDR_W-1:0]        caddr,
    input  logic                          cload,
    output logic signed [OUT_W-1:0]       dout,
    output logic                          valid_out
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic [TAPS-1:0][COEF_W-1:0] coefs;
    logic [TAPS-1:0][DATA_W-1:0] x_q, x_d;
    logic signed [OUT_W-1:0]     dout_q, dout_d;
    logic                        valid_out_q;
    logic                        accept;
    logic signed [PROD_W-1:0]    prod [TAPS];

    // Coefficient load and reset both outrank an incoming sample.
    assign accept = start & valid_in & ~cload & ~rstn;

    core_cmem #(
        .TAPS   (TAPS),
        .COEF_W (COEF_W)
    ) u_cmem (
        .clk1    (clk1),
        .rst_i   (rstn),
        .we_i    (cload),
        .waddr_i (caddr),
        .wdata_i (cin),
        .coefs_o (coefs)
    );

    always_comb begin
        x_d = x_q;
        if (accept) begin
            x_d = {x_q[TAPS-2:0], din};
        end
    end

    // Operands are widened to the product width so the low bits hold the exact signed product.
    for (genvar k = 0; k < TAPS; k++) begin : g_mul
        logic signed [PROD_W-1:0] c_ext, x_ext;
        assign c_ext   = {{(PROD_W-COEF_W){coefs[k][COEF_W-1]}}, coefs[k]};
        assign x_ext   = {{(PROD_W-DATA_W){x_d[k][DATA_W-1]}}, x_d[k]};
        assign prod[k] = c_ext * x_ext;
    end

    always_comb begin
        dout_d = '0;
        for (int k = 0; k < TAPS; k++) begin
            dout_d = dout_d + {{(OUT_W-PROD_W){prod[k][PROD_W-1]}}, prod[k]};
        end
    end

    always_ff @(posedge clk1) begin
        if (rstn) begin
            x_q         <= '0;
            dout_q      <= '0;
            valid_out_q <= 1'b0;
        end else begin
            valid_out_q <= accept;
            if (accept) begin
                x_q    <= x_d;
                dout_q <= dout_d;
            end
        end
    end

    assign dout      = dout_q;
    assign valid_out = valid_out_q;

endmodule

// File: tb/tb_core.sv
// Scoreboard bench for core: a queue-based FIR model predicts every output pulse.
module tb_core;

    logic               clk1 = 1'b0;
    logic               rstn, start, valid_in, cload;
    logic [15:0]        din, cin;
    logic [5:0]         caddr;
    logic signed [40:0] dout;
    logic               valid_out;

    int      checks = 0;
    int      errors = 0;
    longint  exp_q[$];
    longint  cm[64];
    longint  xs[$];

    core dut (
        .clk1      (clk1),
        .rstn      (rstn),
        .start     (start),
        .din       (din),
        .valid_in  (valid_in),
        .cin       (cin),
        .caddr     (caddr),
        .cload     (cload),
        .dout      (dout),
        .valid_out (valid_out)
    );

    always #5 clk1 = ~clk1;

    function automatic longint model_y();
        longint s = 0;
        for (int k = 0; k < 64; k++) s += cm[k] * xs[k];
        return s;
    endfunction

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Drive one cycle, advance the model to match the coming edge, then step past that edge.
    task automatic cyc(input bit r, input bit st, input bit v, input bit cl,
                       input int d, input int c, input int a);
        logic signed [15:0] ds, csg;
        ds = d[15:0];
        csg = c[15:0];
        rstn = r; start = st; valid_in = v; cload = cl;
        din = d[15:0]; cin = c[15:0]; caddr = a[5:0];
        if (r) begin
            for (int i = 0; i < 64; i++) begin cm[i] = 0; xs[i] = 0; end
        end else if (cl) begin
            cm[a[5:0]] = csg;
        end else if (st && v) begin
            xs.push_front(longint'(ds));
            void'(xs.pop_back());
            exp_q.push_back(model_y());
        end
        @(posedge clk1);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk1) begin
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got dout %0d with no accept pending", longint'(dout));
            end else begin
                chk("dout", longint'(dout), exp_q.pop_front());
            end
        end
    end

    initial begin
        longint prev;
        for (int i = 0; i < 64; i++) xs.push_back(0);
        for (int i = 0; i < 64; i++) cm[i] = 0;

        // Reset for two cycles, then an immediate accept.
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 3, 9, 0);
        chk("reset_dout", longint'(dout), 0);
        chk("reset_valid", longint'(valid_out), 0);
        cyc(0, 1, 1, 0, 5, 0, 0);
        idle();

        // Impulse response with c[k] = k+1.
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 64; k++) cyc(0, 0, 0, 1, 0, k + 1, k);
        cyc(0, 1, 1, 0, 1, 0, 0);
        for (int k = 1; k < 64; k++) cyc(0, 1, 1, 0, 0, 0, 0);
        chk("impulse_last", longint'(dout), 64);
        cyc(0, 1, 1, 0, 0, 0, 0);
        chk("impulse_tail", longint'(dout), 0);
        idle();

        // Sign handling: only the oldest tap set to max positive.
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 64; k++) cyc(0, 0, 0, 1, 0, (k == 63) ? 32'h7FFF : 0, k);
        for (int k = 0; k < 64; k++) cyc(0, 1, 1, 0, 32'h8000, 0, 0);
        chk("sign_64th", longint'(dout), -64'sd1073709056);
        idle();

        // Maximum growth.
        for (int k = 0; k < 64; k++) cyc(0, 0, 0, 1, 0, 32'h8000, k);
        for (int k = 0; k < 64; k++) cyc(0, 1, 1, 0, 32'h8000, 0, 0);
        chk("max_growth", longint'(dout), 64'sd68719476736);
        idle();

        // cload outranks a valid sample; the coefficient still lands.
        cyc(0, 1, 1, 0, 1234, 0, 0);
        prev = longint'(dout);
        cyc(0, 1, 1, 1, 777, 32'h0123, 3);
        chk("prio_dout_held", longint'(dout), prev);
        chk("prio_valid_low", longint'(valid_out), 0);
        cyc(0, 1, 1, 0, 17, 0, 0);
        idle();

        // Randomized mix of loads, gaps, back-to-back samples and rare resets.
        for (int n = 0; n < 400; n++) begin
            cyc(($urandom % 150) == 0, ($urandom % 4) != 0, ($urandom % 3) != 0,
                ($urandom % 6) == 0, int'($urandom), int'($urandom), int'($urandom % 64));
        end
        idle();

        // Reset in mid-stream, reload, impulse.
        for (int k = 0; k < 64; k++) cyc(0, 0, 0, 1, 0, int'($urandom), k);
        for (int n = 0; n < 10; n++) cyc(0, 1, 1, 0, int'($urandom), 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 64; k++) cyc(0, 0, 0, 1, 0, k + 1, k);
        cyc(0, 1, 1, 0, 1, 0, 0);
        chk("restart_first", longint'(dout), 1);
        for (int k = 1; k < 65; k++) cyc(0, 1, 1, 0, 0, 0, 0);
        chk("restart_tail", longint'(dout), 0);

        idle();
        idle();
        chk("queue_drain", longint'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
